// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   arb_state_t   : arbiter FSM encoding (idle / holding a grant)
//   ARB_MAXN      : largest supported requester count
//   arb_cnt_width : width of the hold counter for a given hold cap
package rr_mux_arbiter_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int ARB_MAXN = 64;

    // A cap of 0 means "no cap"; keep a 1-bit counter so the width is never zero.
    function automatic int arb_cnt_width(input int maxhold);
        return (maxhold == 0) ? 1 : $clog2(maxhold + 1);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Requester-side bus of the round-robin mux arbiter.
//   Req        : per-requester level request
//   Done       : granted requester finishes its transaction this cycle
//   Grant      : one-hot grant (registered)
//   GrantIdx   : binary mux select (registered)
//   GrantValid : a grant is active (registered)
//   Timeout    : one-cycle pulse after a hold-cap forced release
// master modport = arbiter side, slave modport = requester side.
interface rr_mux_arbiter_if #(
    parameter int N = 4
);
    localparam int SELW = $clog2(N);

    logic [N-1:0]    Req;
    logic            Done;
    logic [N-1:0]    Grant;
    logic [SELW-1:0] GrantIdx;
    logic            GrantValid;
    logic            Timeout;

    modport master (
        input  Req, Done,
        output Grant, GrantIdx, GrantValid, Timeout
    );

    modport slave (
        output Req, Done,
        input  Grant, GrantIdx, GrantValid, Timeout
    );
endinterface

// File: rtl/rr_mux_arbiter_picker.sv
// Combinational round-robin winner selection.
//   Req    : request vector
//   Ptr    : index holding highest priority (must be < N)
//   Found  : at least one request is set
//   WinIdx : first requester at or after Ptr, wrapping past N-1 to 0
module rr_picker #(
    parameter int N = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    Req,
    input  logic [SELW-1:0] Ptr,
    output logic            Found,
    output logic [SELW-1:0] WinIdx
);
    localparam int SW1 = SELW + 1;
    localparam logic [SW1-1:0] N_W = SW1'(N);

    logic [2*N-1:0]  req_dbl;
    logic [N-1:0]    rot;
    logic [SELW-1:0] rot_idx;
    logic [SW1-1:0]  sum;

    always_comb begin
        // Rotate so that Ptr lands on bit 0; the doubled copy supplies the wrap.
        req_dbl = {Req, Req} >> Ptr;
        rot     = req_dbl[N-1:0];

        Found   = 1'b0;
        rot_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!Found && rot[i]) begin
                Found   = 1'b1;
                rot_idx = SELW'(i);
            end
        end

        // Undo the rotation modulo N (valid for non-power-of-two N too).
        sum = {1'b0, rot_idx} + {1'b0, Ptr};
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        WinIdx = sum[SELW-1:0];
    end
endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one wide mux among N requesters.
// A grant is held until Done, until the owner drops Req, or until the
// MAXHOLD cap expires; on release the pointer moves past the owner and the
// next winner is granted on the same edge with no idle bubble.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : requester bus (Req/Done in, Grant/GrantIdx/GrantValid/Timeout out)
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAXHOLD = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    rr_mux_arbiter_if.master   bus
);
    localparam int SELW = $clog2(N);
    localparam int CNTW = arb_cnt_width(MAXHOLD);
    localparam logic [CNTW-1:0] CAP_LAST = CNTW'((MAXHOLD == 0) ? 0 : MAXHOLD - 1);

    if (N < 2 || N > ARB_MAXN) begin : g_bad_n
        $error("rr_mux_arbiter: N out of range 2..64");
    end

    arb_state_t      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [SELW-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic            timeout_q, timeout_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic            release_now;
    logic            cap_hit;
    logic [SELW-1:0] ptr_after;
    logic [SELW-1:0] pick_ptr;
    logic            found;
    logic [SELW-1:0] win_idx;

    // Release decision depends only on inputs and state, so the picker can
    // see the post-release pointer in the same cycle without a loop.
    always_comb begin
        cap_hit     = 1'b0;
        release_now = 1'b0;
        ptr_after   = (idx_q == SELW'(N - 1)) ? '0 : idx_q + SELW'(1);
        pick_ptr    = ptr_q;
        if (state_q == ARB_BUSY) begin
            cap_hit     = (MAXHOLD != 0) && (cnt_q == CAP_LAST) && !bus.Done;
            release_now = bus.Done || !bus.Req[idx_q] || cap_hit;
            if (release_now) begin
                pick_ptr = ptr_after;
            end
        end
    end

    rr_picker #(.N(N)) u_picker (
        .Req    (bus.Req),
        .Ptr    (pick_ptr),
        .Found  (found),
        .WinIdx (win_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    idx_d            = win_idx;
                    valid_d          = 1'b1;
                    cnt_d            = '0;
                    state_d          = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (release_now) begin
                    ptr_d     = ptr_after;
                    timeout_d = cap_hit;
                    cnt_d     = '0;
                    if (found) begin
                        grant_d          = '0;
                        grant_d[win_idx] = 1'b1;
                        idx_d            = win_idx;
                    end else begin
                        grant_d = '0;
                        valid_d = 1'b0;
                        state_d = ARB_IDLE;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ARB_IDLE;
            grant_q   <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.Grant      = grant_q;
    assign bus.GrantIdx   = idx_q;
    assign bus.GrantValid = valid_q;
    assign bus.Timeout    = timeout_q;
endmodule
